// File: rtl/skid_fifo_pkg.sv
// Shared helpers for skid_fifo: log2 sizing and the DEPTH power-of-2 check.
package skid_fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/skid_fifo_mem.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
module skid_fifo_mem #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [DEPTH-1:0][W-1:0] mem_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_comb begin
      mem_d[i] = mem_q[i];
      if (we && (waddr == PW'(i))) mem_d[i] = wdata;
    end

    always_ff @(posedge clk) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/skid_fifo.sv
// DEPTH-entry elastic buffer on a valid/ready stream; din_ready decodes registered level only.
// Optional SKID_FIFO_FLUSH_EN adds a flush input that empties the buffer in one cycle.
module skid_fifo
  import skid_fifo_pkg::*;
#(
  parameter int DIN_WIDTH    = 32,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIN_WIDTH-1:0]      din,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic [DIN_WIDTH-1:0]      dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [clog2(DEPTH):0]     level,
`ifdef SKID_FIFO_FLUSH_EN
  input  logic                      flush,
`endif
  output logic                      almost_full
);

  localparam int PW = clog2(DEPTH);
  localparam int LW = PW + 1;

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("skid_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("skid_fifo: AFULL_THRESH must be in 1..DEPTH");
  end

  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          push, pop, flush_i, we;
  logic [DIN_WIDTH-1:0] rdata;

`ifdef SKID_FIFO_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  always_comb begin
    din_ready  = (level_q != LW'(DEPTH));
    dout_valid = (level_q != '0);
    push       = din_valid & din_ready;
    pop        = dout_valid & dout_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    we         = 1'b0;
    if (flush_i) begin
      // Flush drops everything, including the word offered this cycle.
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      we = push & rst;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  skid_fifo_mem #(
    .W     (DIN_WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Storage is never cleared, so mask the head word while empty to give a clean 0.
  assign dout        = dout_valid ? rdata : '0;
  assign level       = level_q;
  assign almost_full = (level_q >= LW'(AFULL_THRESH));

  always @(posedge clk) begin
    if (rst) assert (level_q <= LW'(DEPTH));
  end

endmodule

// File: tb/tb_skid_fifo.sv
// Directed bench for skid_fifo (DIN_WIDTH=32, DEPTH=4, AFULL_THRESH=3).
module tb_skid_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [2:0]  level;
  logic        almost_full;
`ifdef SKID_FIFO_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  skid_fifo #(.DIN_WIDTH(32), .DEPTH(4), .AFULL_THRESH(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .level       (level),
`ifdef SKID_FIFO_FLUSH_EN
    .flush       (flush),
`endif
    .almost_full (almost_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int lvl, input logic [31:0] head);
    chk({tag, ".level"}, 32'(level), 32'(lvl));
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(lvl != 0));
    chk({tag, ".din_ready"}, 32'(din_ready), 32'(lvl != 4));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(lvl >= 3));
    if (lvl != 0) chk({tag, ".dout"}, dout, head);
  endtask

  logic [31:0] q[$];
  bit          do_push, do_pop;
  logic [31:0] got_dead;

  initial begin
    rst = 1'b0; din = 32'h55; din_valid = 1'b1; dout_ready = 1'b0;

    // reset with input offered
    repeat (3) tick();
    chk_state("reset", 0, 0);
    chk("reset.dout", dout, 32'h0);

    // pass-through, 1-cycle latency, no bubbles
    rst = 1'b1; dout_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      din = 32'(i); din_valid = 1'b1;
      tick();
      chk_state($sformatf("pass%0d", i), 1, 32'(i));
    end
    din_valid = 1'b0;
    tick();
    chk_state("pass_drain", 0, 0);

    // fill while stalled
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = 32'hA0 + 32'(i); din_valid = 1'b1;
      tick();
      chk_state($sformatf("fill%0d", i), i + 1, 32'hA0);
    end
    din = 32'hA4;
    repeat (2) tick();
    chk_state("full_hold", 4, 32'hA0);

    // pop while full: din_ready must not follow dout_ready combinationally
    dout_ready = 1'b1;
    #1;
    chk("full_pop.din_ready_same_cycle", 32'(din_ready), 32'h0);
    tick();
    dout_ready = 1'b0;
    chk_state("full_pop", 3, 32'hA1);
    tick();
    chk_state("accept_a4", 4, 32'hA1);
    din = 32'hA5; dout_ready = 1'b1;
    tick();
    chk_state("drain_a1", 3, 32'hA2);
    tick();
    din_valid = 1'b0;
    chk_state("drain_a2", 3, 32'hA3);
    tick();
    chk_state("drain_a3", 2, 32'hA4);
    tick();
    chk_state("drain_a4", 1, 32'hA5);
    tick();
    chk_state("drain_a5", 0, 0);

    // mid-stream reset discards contents
    dout_ready = 1'b0; din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin din = 32'hB0 + 32'(i); tick(); end
    chk_state("pre_rst", 3, 32'hB0);
    rst = 1'b0; din_valid = 1'b0;
    tick();
    chk_state("mid_rst", 0, 0);
    rst = 1'b1;

    // pseudo-random traffic against a queue model
    for (int c = 0; c < 600; c++) begin
      din        = $urandom;
      din_valid  = ($urandom_range(0, 1) == 1);
      dout_ready = ($urandom_range(0, 9) < 3);
      do_push    = din_valid && (q.size() != 4);
      do_pop     = dout_ready && (q.size() != 0);
      tick();
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(din);
      chk_state($sformatf("rand%0d", c), q.size(), (q.size() != 0) ? q[0] : 32'h0);
    end
    din_valid = 1'b0; dout_ready = 1'b1;
    repeat (5) tick();
    chk_state("rand_drain", 0, 0);

`ifdef SKID_FIFO_FLUSH_EN
    dout_ready = 1'b0; din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin din = 32'hC0 + 32'(i); tick(); end
    chk_state("pre_flush", 3, 32'hC0);
    din = 32'hDEAD; flush = 1'b1;
    tick();
    flush = 1'b0; din_valid = 1'b0;
    chk_state("flush", 0, 0);
    dout_ready = 1'b1; got_dead = 32'h0;
    repeat (4) begin
      tick();
      if (dout_valid && dout == 32'hDEAD) got_dead = 32'h1;
    end
    chk("flush.dead_seen", got_dead, 32'h0);
    din = 32'hE1; din_valid = 1'b1; dout_ready = 1'b0;
    tick();
    din_valid = 1'b0;
    chk_state("post_flush", 1, 32'hE1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
